// File: rtl/dma_controller.sv
// dma_controller: single-channel memory-to-memory DMA engine and owner of the
// shared address/data buses. The CPU programs it with one bus cycle to
// DMA_ADDR carrying {ignored, cnt, dst, src}. While a transfer runs, ADE is
// held high so the CPU releases both buses. The engine then copies one word
// per RD/WR pair.
// Optional feature: define DMA_FAIR_EN to hand the bus back to the CPU for
// one cycle (YIELD) after every 4th word of a transfer that is still running.
module dma_controller #(
  parameter int unsigned DMA_ADDR = 5000,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned CNT_W    = 6
) (
  input  logic        CLK,
  input  logic        RST_N,
  inout  wire  [31:0] address_Bus,
  inout  wire  [31:0] Data_Bus,
  input  logic        Read,
  input  logic        Write,
  output logic        ADE,
  output logic        DMA_Read,
  output logic        DMA_Write,
  output logic        busy,
  output logic        done
);

`ifdef DMA_FAIR_EN
  typedef enum logic [2:0] {IDLE, GRANT, RD, WR, REL, YIELD} state_t;
`else
  typedef enum logic [2:0] {IDLE, GRANT, RD, WR, REL} state_t;
`endif

  state_t            state;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       data_buf;
`ifdef DMA_FAIR_EN
  logic [1:0]        wcnt;
`endif

  logic              cmd_hit;
  logic [CNT_W-1:0]  cmd_cnt;

  // Command qualification: a plain bus cycle (no read/write strobe) to DMA_ADDR.
  always_comb begin
    cmd_cnt = Data_Bus[2*ADDR_W +: CNT_W];
    cmd_hit = !ADE && (address_Bus == 32'(DMA_ADDR)) && !Read && !Write;
  end

  // Bus drivers are decoded from the state register, so an asynchronous reset
  // releases both buses in the same cycle.
  assign address_Bus = (state == RD) ? 32'(src) :
                       (state == WR) ? 32'(dst) : 'z;
  assign Data_Bus    = (state == WR) ? data_buf : 'z;

  // Transfer FSM; all handshake outputs are registered alongside the state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      ADE       <= 1'b0;
      DMA_Read  <= 1'b0;
      DMA_Write <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      src       <= '0;
      dst       <= '0;
      cnt       <= '0;
      data_buf  <= '0;
`ifdef DMA_FAIR_EN
      wcnt      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_hit && (cmd_cnt != '0)) begin
            src   <= Data_Bus[ADDR_W-1:0];
            dst   <= Data_Bus[2*ADDR_W-1:ADDR_W];
            cnt   <= cmd_cnt;
            state <= GRANT;
            busy  <= 1'b1;
            ADE   <= 1'b1;
`ifdef DMA_FAIR_EN
            wcnt  <= '0;
`endif
          end
        end
        GRANT: begin
          state    <= RD;
          DMA_Read <= 1'b1;
        end
        RD: begin
          data_buf  <= Data_Bus;
          DMA_Read  <= 1'b0;
          DMA_Write <= 1'b1;
          state     <= WR;
        end
        WR: begin
          src       <= src + ADDR_W'(1);
          dst       <= dst + ADDR_W'(1);
          cnt       <= cnt - CNT_W'(1);
          DMA_Write <= 1'b0;
`ifdef DMA_FAIR_EN
          wcnt      <= wcnt + 2'd1;
`endif
          if (cnt == CNT_W'(1)) begin
            state <= REL;
            ADE   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
`ifdef DMA_FAIR_EN
          end else if (wcnt == 2'd3) begin
            state <= YIELD;
            ADE   <= 1'b0;
`endif
          end else begin
            state    <= RD;
            DMA_Read <= 1'b1;
          end
        end
        REL: begin
          state <= IDLE;
        end
`ifdef DMA_FAIR_EN
        YIELD: begin
          state <= GRANT;
          ADE   <= 1'b1;
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller: a behavioural CPU bus driver and a
// 1024-word data memory (combinational read, posedge write) share the buses.
module tb_dma_controller;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        Read = 1'b0;
  logic        Write = 1'b0;
  logic        ADE, DMA_Read, DMA_Write, busy, done;
  wire  [31:0] address_Bus;
  wire  [31:0] Data_Bus;

  logic        cpu_drive = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_data = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem [0:1023];

  int n_checks = 0;
  int n_errors = 0;

  dma_controller #(.DMA_ADDR(5000), .ADDR_W(10), .CNT_W(6)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .address_Bus(address_Bus), .Data_Bus(Data_Bus),
    .Read(Read), .Write(Write),
    .ADE(ADE), .DMA_Read(DMA_Read), .DMA_Write(DMA_Write),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  assign address_Bus = cpu_drive ? cpu_addr : 'z;
  assign Data_Bus    = cpu_drive ? cpu_data :
                       (DMA_Read ? mem[address_Bus[9:0]] : 'z);

  function automatic logic [31:0] pat(input int unsigned a);
    return 32'h5A00_0000 + a * 32'h0001_0003;
  endfunction

  // Initial fill on the first clocks, then DMA writes only.
  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
    end else if (DMA_Write) begin
      mem[address_Bus[9:0]] <= Data_Bus;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cmd(input int unsigned s, input int unsigned d, input int unsigned n);
    logic [9:0] s10, d10;
    logic [5:0] n6;
    s10 = 10'(s);
    d10 = 10'(d);
    n6  = 6'(n);
    return {6'h2A, n6, d10, s10};
  endfunction

  function automatic int yields(input int n);
`ifdef DMA_FAIR_EN
    return (n - 1) / 4;
`else
    return 0;
`endif
  endfunction

  // One CPU bus cycle; returns #1 after the edge that samples it.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr);
    @(negedge CLK);
    cpu_addr  = a;
    cpu_data  = d;
    Read      = rd;
    Write     = wr;
    cpu_drive = 1'b1;
    @(posedge CLK); #1;
    cpu_drive = 1'b0;
    Read      = 1'b0;
    Write     = 1'b0;
  endtask

  task automatic run_xfer(input string tag, input int unsigned s, input int unsigned d, input int n);
    int ade_n, done_n, done_at, gaps, upper_bad, excl_bad;
    logic prev, busy1;
    ade_n = 0; done_n = 0; done_at = 0; gaps = 0; upper_bad = 0; excl_bad = 0;
    prev = 1'b0;
    issue(32'd5000, cmd(s, d, n), 1'b0, 1'b0);
    busy1 = busy;
    for (int k = 1; k <= 48; k++) begin
      if (ADE) ade_n++;
      if (done) begin done_n++; done_at = k; end
      if (prev && !ADE && busy) gaps++;
      prev = ADE;
      if ((DMA_Read || DMA_Write) && (address_Bus[31:10] != '0)) upper_bad++;
      if (DMA_Read && DMA_Write) excl_bad++;
      @(posedge CLK); #1;
    end
    check({tag, "_busy_rise"}, 32'(busy1), 32'd1);
    check({tag, "_ade_cycles"}, 32'(ade_n), 32'(1 + 2 * n + yields(n)));
    check({tag, "_done_count"}, 32'(done_n), 32'd1);
    check({tag, "_done_at"}, 32'(done_at), 32'(2 + 2 * n + 2 * yields(n)));
    check({tag, "_ade_gaps"}, 32'(gaps), 32'(yields(n)));
    check({tag, "_upper_zero"}, 32'(upper_bad), 32'd0);
    check({tag, "_strobe_excl"}, 32'(excl_bad), 32'd0);
    for (int k = 0; k < n; k++)
      check({tag, "_mem"}, mem[(d + 32'(k)) % 1024], pat((s + 32'(k)) % 1024));
  endtask

  initial begin
    logic [31:0] neg_addr [4];
    logic        neg_wr   [4];
    logic        neg_rd   [4];
    int          seen;

    // Reset state while memory is filled
    repeat (3) @(posedge CLK);
    mem_ready = 1'b1;
    #1;
    check("rst_ade", 32'(ADE), 32'd0);
    check("rst_rd", 32'(DMA_Read), 32'd0);
    check("rst_wr", 32'(DMA_Write), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // Basic copy, 4 words
    run_xfer("basic", 10, 100, 4);

    // Zero count is dropped
    issue(32'd5000, cmd(200, 300, 0), 1'b0, 1'b0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (ADE || busy || done) seen++;
      @(posedge CLK); #1;
    end
    check("zero_activity", 32'(seen), 32'd0);
    check("zero_mem", mem[300], pat(300));

    // Source wraps 1023 -> 0
    run_xfer("wrap", 1022, 500, 3);

    // Decode qualification
    neg_addr[0] = 32'd4999; neg_rd[0] = 1'b0; neg_wr[0] = 1'b0;
    neg_addr[1] = 32'd5001; neg_rd[1] = 1'b0; neg_wr[1] = 1'b0;
    neg_addr[2] = 32'd5000; neg_rd[2] = 1'b0; neg_wr[2] = 1'b1;
    neg_addr[3] = 32'd5000; neg_rd[3] = 1'b1; neg_wr[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(neg_addr[i], cmd(20, 40, 2), neg_rd[i], neg_wr[i]);
      check("decode_no_busy", 32'(busy), 32'd0);
      @(posedge CLK); #1;
      check("decode_no_ade", 32'(ADE), 32'd0);
    end
    check("decode_mem_untouched", mem[40], pat(40));
    run_xfer("decode_ok", 20, 40, 2);

    // Reset during WR of word 2
    issue(32'd5000, cmd(30, 60, 4), 1'b0, 1'b0);
    repeat (4) begin @(posedge CLK); #1; end
    check("mid_in_wr", 32'(DMA_Write), 32'd1);
    check("mid_wr_addr", address_Bus, 32'd61);
    #2;
    RST_N = 1'b0;
    #1;
    check("mid_ade", 32'(ADE), 32'd0);
    check("mid_strobes", {30'd0, DMA_Read, DMA_Write}, 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    cpu_addr = 32'hDEAD_BEEF;
    cpu_data = 32'h1234_5678;
    cpu_drive = 1'b1;
    #1;
    check("mid_abus_free", address_Bus, 32'hDEAD_BEEF);
    check("mid_dbus_free", Data_Bus, 32'h1234_5678);
    cpu_drive = 1'b0;
    @(posedge CLK); #1;
    check("mid_word1", mem[60], pat(30));
    check("mid_word2_kept", mem[61], pat(61));
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // 8 words: crosses the 4-word boundary
    run_xfer("long", 700, 800, 8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
